// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Word width, FSM state encoding and the packed result-flag bundle.
package serial_subtractor_pkg;

   localparam int unsigned HACK_WORD_WIDTH = 16;

   typedef enum logic [1:0] {
      SS_IDLE = 2'd0,
      SS_RUN  = 2'd1,
      SS_DONE = 2'd2
   } ss_state_e;

   typedef struct packed {
      logic borrow;
      logic ovf;
      logic zr;
      logic ng;
   } ss_flags_t;

   // Bit counter must hold WIDTH-1 with one spare bit of headroom.
   function automatic int unsigned ss_cnt_width(input int unsigned width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor.
// The master issues operands and start; the slave returns status and result.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = serial_subtractor_pkg::HACK_WORD_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             ovf;
   logic             zr;
   logic             ng;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, ovf, zr, ng
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, ovf, zr, ng
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial word subtractor (diff = a - b), LSB-first, one bit per clock.
// A single full-subtractor cell is reused each cycle with its borrow held in a flop.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = HACK_WORD_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus
);

   localparam int unsigned CW = ss_cnt_width(WIDTH);

   ss_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bin_q, bin_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   ss_flags_t        flags_q, flags_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             load_c;
   logic             shift_c;
   logic             last_c;
   logic             ai_c, bi_c, d_c, bout_c;

   assign last_c = (cnt_q == CW'(WIDTH - 1));
   assign ai_c   = a_sh_q[0];
   assign bi_c   = b_sh_q[0];

   full_subtractor u_fs (
      .a    (ai_c),
      .b    (bi_c),
      .bin  (bin_q),
      .d    (d_c),
      .bout (bout_c)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SS_IDLE: if (bus.start) state_d = SS_RUN;
         SS_RUN:  if (last_c)    state_d = SS_DONE;
         SS_DONE: state_d = bus.start ? SS_RUN : SS_IDLE;
         default: state_d = SS_IDLE;
      endcase
   end

   // FSM outputs: datapath strobes and next busy/done
   always_comb begin
      load_c  = 1'b0;
      shift_c = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         SS_IDLE, SS_DONE: begin
            if (bus.start) begin
               load_c = 1'b1;
               busy_d = 1'b1;
            end
         end
         SS_RUN: begin
            shift_c = 1'b1;
            busy_d  = ~last_c;
            done_d  = last_c;
         end
         default: ;
      endcase
   end

   // Datapath next state; visible outputs only move on the final bit
   always_comb begin
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      bin_d   = bin_q;
      diff_d  = diff_q;
      flags_d = flags_q;
      if (load_c) begin
         cnt_d  = '0;
         a_sh_d = bus.a;
         b_sh_d = bus.b;
         res_d  = '0;
         bin_d  = 1'b0;
      end else if (shift_c) begin
         cnt_d  = cnt_q + CW'(1);
         a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
         b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
         res_d  = {d_c, res_q[WIDTH-1:1]};
         bin_d  = bout_c;
         if (last_c) begin
            diff_d         = res_d;
            flags_d.borrow = bout_c;
            flags_d.ovf    = (ai_c ^ bi_c) & (ai_c ^ d_c);
            flags_d.zr     = (res_d == '0);
            flags_d.ng     = d_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         bin_q   <= 1'b0;
         diff_q  <= '0;
         flags_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         bin_q   <= bin_d;
         diff_q  <= diff_d;
         flags_q <= flags_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.borrow = flags_q.borrow;
   assign bus.ovf    = flags_q.ovf;
   assign bus.zr     = flags_q.zr;
   assign bus.ng     = flags_q.ng;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus hand-written
// sequences for ignored start, mid-run reset and back-to-back operation.
module tb_serial_subtractor;
   import serial_subtractor_pkg::*;

   localparam int unsigned W = HACK_WORD_WIDTH;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
      logic         zr;
      logic         ng;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   full_subtractor u_fs (
      .a    (fs_a),
      .b    (fs_b),
      .bin  (fs_bin),
      .d    (fs_d),
      .bout (fs_bout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands with start for one edge (edge 0), then scrub the inputs
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
   endtask

   // Edges 1..W-1 must show busy, no done and the old result; then step to edge W
   task automatic run_wait(input string tag, input logic [W-1:0] hold_diff);
      logic ok;
      ok = 1'b1;
      for (int c = 1; c < int'(W); c++) begin
         tick();
         if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.diff !== hold_diff) ok = 1'b0;
      end
      check({tag, "_running"}, 32'(ok), 32'd1);
      tick();
   endtask

   task automatic check_result(input string tag, input vec_t v);
      check({tag, "_done"},   32'({bus.done, bus.busy}), 32'b10);
      check({tag, "_diff"},   32'(bus.diff), 32'(v.diff));
      check({tag, "_flags"},  32'({bus.borrow, bus.ovf, bus.zr, bus.ng}),
                              32'({v.borrow, v.ovf, v.zr, v.ng}));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      vec_t v;
      logic [W-1:0] prev;
      int   ref_d;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      rst_n     = 1'b0;

      // Standalone cell: compare against integer a - b - bin
      for (int i = 0; i < 8; i++) begin
         {fs_a, fs_b, fs_bin} = 3'(i);
         #1;
         ref_d = int'(fs_a) - int'(fs_b) - int'(fs_bin);
         check($sformatf("fs_%0d", i), 32'({fs_d, fs_bout}),
               32'({ref_d[0], ref_d < 0}));
      end

      repeat (2) tick();
      check("reset_diff",  32'(bus.diff), 32'd0);
      check("reset_flags", 32'({bus.busy, bus.done, bus.borrow, bus.ovf, bus.zr, bus.ng}), 32'd0);
      rst_n = 1'b1;
      tick();

      vecs[0] = '{16'd5,    16'd3,    16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'd3,    16'd5,    16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};

      prev = '0;
      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         run_wait($sformatf("vec%0d", i), prev);
         check_result($sformatf("vec%0d", i), vecs[i]);
         tick();
         check($sformatf("vec%0d_pulse", i), 32'({bus.done, bus.busy}), 32'b00);
         prev = vecs[i].diff;
      end

      // Start during RUN is ignored
      start_op(16'h8000, 16'h0001);
      repeat (4) tick();
      bus.start = 1'b1;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      check("ign_running", 32'({bus.done, bus.busy}), 32'b01);
      tick();
      v = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
      check_result("ign", v);
      tick();
      check("ign_after", 32'({bus.done, bus.busy}), 32'b00);

      // Reset mid-run clears everything immediately
      start_op(16'd7, 16'd2);
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      check("rst_mid_diff",  32'(bus.diff), 32'd0);
      check("rst_mid_flags", 32'({bus.busy, bus.done, bus.borrow, bus.ovf, bus.zr, bus.ng}), 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      start_op(16'd9, 16'd4);
      run_wait("post_rst", 16'h0000);
      v = '{16'd9, 16'd4, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0};
      check_result("post_rst", v);
      tick();

      // Back-to-back: new start accepted in the done cycle
      start_op(16'd10, 16'd1);
      run_wait("b2b0", 16'h0005);
      v = '{16'd10, 16'd1, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0};
      check_result("b2b0", v);
      bus.start = 1'b1;
      bus.a     = 16'd1;
      bus.b     = 16'd10;
      tick();
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      check("b2b_seam", 32'({bus.busy, bus.done, bus.diff}), 32'({1'b1, 1'b0, 16'h0009}));
      run_wait("b2b1", 16'h0009);
      v = '{16'd1, 16'd10, 16'hFFF7, 1'b1, 1'b0, 1'b0, 1'b1};
      check_result("b2b1", v);
      tick();
      check("b2b1_pulse", 32'({bus.done, bus.busy}), 32'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
